// File: rtl/axi_rd_burst_sched_pkg.sv
// Shared definitions for the AXI read/write burst schedulers: FSM states,
// beat/page geometry and the burst length rule (max burst, 4 KB page, remaining).
package axi_rd_burst_sched_pkg;

    localparam int BEAT_BYTES = 64;
    localparam int PAGE_BEATS = 64;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_GAP   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

    // Smallest of the remaining beats, the burst cap and the beats left in the 4 KB page.
    function automatic logic [7:0] burst_len(
        input logic [63:0] remaining,
        input logic [5:0]  addr_lo,
        input logic [7:0]  max_burst
    );
        logic [7:0] room;
        logic [7:0] len;
        room = 8'(PAGE_BEATS) - {2'b00, addr_lo};
        len  = max_burst;
        if (room < len) begin
            len = room;
        end
        if (remaining < 64'(len)) begin
            len = remaining[7:0];
        end
        return len;
    endfunction

endpackage

// File: rtl/axi_rd_burst_sched.sv
// Splits one large read command into AXI-legal bursts for the read master's
// local command port, caps bursts in flight and reports completion status.
module axi_rd_burst_sched
    import axi_rd_burst_sched_pkg::*;
#(
    parameter int ADDR_WIDTH      = 64,
    parameter int LEN_WIDTH       = 32,
    parameter int MAX_BURST       = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]  cmd_beats,
    input  logic                  cmd_abort,
    output logic                  cmd_done,
    output logic [1:0]            cmd_status,
    output logic                  busy,
    output logic [2:0]            outstanding,
    output logic                  clear,
    output logic                  lcl_ostart,
    output logic [ADDR_WIDTH-1:0] lcl_oaddr,
    output logic [7:0]            lcl_onum,
    input  logic                  lcl_obusy,
    input  logic                  lcl_odone,
    input  logic [3:0]            rd_error
);

    localparam logic [2:0]            MAX_OUT_C   = 3'(MAX_OUTSTANDING);
    localparam logic [7:0]            MAX_BURST_C = 8'(MAX_BURST);
    localparam logic [ADDR_WIDTH-1:0] BEAT_MASK_C = ADDR_WIDTH'(BEAT_BYTES - 1);

    sched_state_t          state_r;
    sched_state_t          state_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [LEN_WIDTH-1:0]  remaining_r;
    logic [2:0]            outstanding_r;
    logic                  err_r;
    logic                  abt_r;
    logic                  cmd_ready_r;
    logic                  cmd_done_r;
    logic [1:0]            cmd_status_r;
    logic                  busy_r;
    logic                  clear_r;
    logic                  lcl_ostart_r;
    logic [ADDR_WIDTH-1:0] lcl_oaddr_r;
    logic [7:0]            lcl_onum_r;

    logic                  accept_s;
    logic                  issue_ok_s;
    logic                  issue_s;
    logic                  stray_s;
    logic                  dec_s;
    logic [7:0]            len_s;
    logic [2:0]            out_nxt_s;
    logic                  err_nxt_s;
    logic                  abt_nxt_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; an abort in ISSUE takes priority over issuing.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = (cmd_beats == {LEN_WIDTH{1'b0}}) ? ST_DRAIN : ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cmd_abort) begin
                    state_nxt_s = ST_DRAIN;
                end else if (issue_ok_s) begin
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_GAP:   state_nxt_s = (remaining_r != {LEN_WIDTH{1'b0}}) ? ST_ISSUE : ST_DRAIN;
            ST_DRAIN: state_nxt_s = (outstanding_r == 3'd0) ? ST_DONE : ST_DRAIN;
            ST_DONE:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Control strobes and next values of the in-flight count and sticky flags.
    always_comb begin
        len_s      = burst_len(64'(remaining_r), addr_r[11:6], MAX_BURST_C);
        accept_s   = cmd_valid & cmd_ready_r;
        issue_ok_s = ~lcl_obusy & (outstanding_r < MAX_OUT_C) & ~cmd_abort;
        issue_s    = (state_r == ST_ISSUE) & issue_ok_s;
        stray_s    = lcl_odone & (outstanding_r == 3'd0);
        dec_s      = lcl_odone & ~stray_s;

        if (issue_s && !dec_s) begin
            out_nxt_s = outstanding_r + 3'd1;
        end else if (!issue_s && dec_s) begin
            out_nxt_s = outstanding_r - 3'd1;
        end else begin
            out_nxt_s = outstanding_r;
        end

        if (accept_s) begin
            err_nxt_s = 1'b0;
        end else if (((state_r != ST_IDLE) && (rd_error != 4'd0)) || stray_s) begin
            err_nxt_s = 1'b1;
        end else begin
            err_nxt_s = err_r;
        end

        // Abort only counts once issuing would still have had work to do.
        if (accept_s) begin
            abt_nxt_s = 1'b0;
        end else if (cmd_abort && ((state_r == ST_ISSUE) ||
                     ((state_r == ST_DRAIN) && (remaining_r != {LEN_WIDTH{1'b0}})))) begin
            abt_nxt_s = 1'b1;
        end else begin
            abt_nxt_s = abt_r;
        end
    end

    // Datapath and registered outputs; status is captured as DONE is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r        <= {ADDR_WIDTH{1'b0}};
            remaining_r   <= {LEN_WIDTH{1'b0}};
            outstanding_r <= 3'd0;
            err_r         <= 1'b0;
            abt_r         <= 1'b0;
            cmd_ready_r   <= 1'b1;
            cmd_done_r    <= 1'b0;
            cmd_status_r  <= 2'b00;
            busy_r        <= 1'b0;
            clear_r       <= 1'b0;
            lcl_ostart_r  <= 1'b0;
            lcl_oaddr_r   <= {ADDR_WIDTH{1'b0}};
            lcl_onum_r    <= 8'd0;
        end else begin
            if (accept_s) begin
                addr_r      <= cmd_addr & ~BEAT_MASK_C;
                remaining_r <= cmd_beats;
            end else if (issue_s) begin
                addr_r      <= addr_r + ADDR_WIDTH'(len_s) * ADDR_WIDTH'(BEAT_BYTES);
                remaining_r <= remaining_r - LEN_WIDTH'(len_s);
            end
            if (issue_s) begin
                lcl_oaddr_r <= addr_r;
                lcl_onum_r  <= len_s;
            end
            outstanding_r <= out_nxt_s;
            err_r         <= err_nxt_s;
            abt_r         <= abt_nxt_s;
            clear_r       <= accept_s;
            lcl_ostart_r  <= issue_s;
            cmd_ready_r   <= (state_nxt_s == ST_IDLE);
            busy_r        <= (state_nxt_s != ST_IDLE);
            cmd_done_r    <= (state_nxt_s == ST_DONE);
            cmd_status_r  <= (state_nxt_s == ST_DONE) ? {abt_nxt_s, err_nxt_s} : 2'b00;
        end
    end

    assign cmd_ready   = cmd_ready_r;
    assign cmd_done    = cmd_done_r;
    assign cmd_status  = cmd_status_r;
    assign busy        = busy_r;
    assign outstanding = outstanding_r;
    assign clear       = clear_r;
    assign lcl_ostart  = lcl_ostart_r;
    assign lcl_oaddr   = lcl_oaddr_r;
    assign lcl_onum    = lcl_onum_r;

endmodule

// File: tb/tb_axi_rd_burst_sched.sv
// Randomized bench for axi_rd_burst_sched: a burst list computed from the
// address/length rules, a simple read-master responder and directed corner cases.
module tb_axi_rd_burst_sched;

    localparam int MAX_BURST       = 32;
    localparam int MAX_OUTSTANDING = 4;

    typedef struct {
        logic [63:0] addr;
        int          num;
    } burst_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] cmd_addr;
    logic [31:0] cmd_beats;
    logic        cmd_abort;
    logic        cmd_done;
    logic [1:0]  cmd_status;
    logic        busy;
    logic [2:0]  outstanding;
    logic        clear;
    logic        lcl_ostart;
    logic [63:0] lcl_oaddr;
    logic [7:0]  lcl_onum;
    logic        lcl_obusy;
    logic        lcl_odone;
    logic [3:0]  rd_error;

    int     n_tests = 0;
    int     n_fail  = 0;
    int     n_starts = 0;
    int     model_out = 0;
    int     obusy_cnt = 0;
    bit     auto_mode = 1'b0;
    burst_t exp_q[$];
    int     pend[$];

    axi_rd_burst_sched #(
        .ADDR_WIDTH(64), .LEN_WIDTH(32),
        .MAX_BURST(MAX_BURST), .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_beats(cmd_beats), .cmd_abort(cmd_abort),
        .cmd_done(cmd_done), .cmd_status(cmd_status), .busy(busy),
        .outstanding(outstanding), .clear(clear),
        .lcl_ostart(lcl_ostart), .lcl_oaddr(lcl_oaddr), .lcl_onum(lcl_onum),
        .lcl_obusy(lcl_obusy), .lcl_odone(lcl_odone), .rd_error(rd_error)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected burst list straight from the rules: min(remaining, cap, beats left in the 4 KB page).
    function automatic void build_bursts(input logic [63:0] a_in, input longint unsigned beats);
        logic [63:0]     a;
        longint unsigned r;
        longint unsigned len;
        longint unsigned page_left;
        burst_t          b;
        a = a_in & ~64'd63;
        r = beats;
        while (r > 0) begin
            page_left = 64 - ((a / 64) % 64);
            len = r;
            if (len > MAX_BURST) len = MAX_BURST;
            if (len > page_left) len = page_left;
            b.addr = a;
            b.num  = int'(len);
            exp_q.push_back(b);
            a = a + len * 64;
            r = r - len;
        end
    endfunction

    // One clock: check starts and the in-flight count, then drive the master side.
    task automatic tick();
        logic   done_drv;
        int     old;
        burst_t b;
        done_drv = lcl_odone;
        @(posedge clk);
        #1;
        if (lcl_ostart) begin
            n_starts++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_start", 64'(lcl_onum), 64'd0);
            end else begin
                b = exp_q.pop_front();
                check_eq("burst_addr", lcl_oaddr, b.addr);
                check_eq("burst_num", 64'(lcl_onum), 64'(b.num));
            end
            if (auto_mode) begin
                obusy_cnt = $urandom_range(0, 3);
                pend.push_back($urandom_range(1, 12));
            end
        end
        old = model_out;
        model_out = old + (lcl_ostart ? 1 : 0) - ((done_drv && old != 0) ? 1 : 0);
        check_eq("outstanding", 64'(outstanding), 64'(model_out));
        lcl_odone = 1'b0;
        if (auto_mode) begin
            lcl_obusy = (obusy_cnt > 0) || ($urandom_range(0, 7) == 0);
            if (obusy_cnt > 0) obusy_cnt--;
            foreach (pend[i]) pend[i]--;
            for (int i = 0; i < pend.size(); i++) begin
                if (pend[i] <= 0) begin
                    pend.delete(i);
                    lcl_odone = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic start_cmd(input logic [63:0] a, input logic [31:0] beats);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 10) begin
            tick();
            guard++;
        end
        check_eq("ready_before_cmd", 64'(cmd_ready), 64'd1);
        build_bursts(a, longint'(beats));
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_beats = beats;
        tick();
        cmd_valid = 1'b0;
        check_eq("clear_pulse", 64'(clear), 64'd1);
        check_eq("busy_after_accept", 64'(busy), 64'd1);
        check_eq("ready_after_accept", 64'(cmd_ready), 64'd0);
    endtask

    task automatic wait_done(input int budget, output logic [1:0] st);
        int c;
        c = 0;
        while (!cmd_done && c < budget) begin
            tick();
            c++;
        end
        check_eq("done_seen", 64'(cmd_done), 64'd1);
        st = cmd_status;
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check_eq("rst_cmd_done", 64'(cmd_done), 64'd0);
        check_eq("rst_cmd_status", 64'(cmd_status), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_outstanding", 64'(outstanding), 64'd0);
        check_eq("rst_clear", 64'(clear), 64'd0);
        check_eq("rst_ostart", 64'(lcl_ostart), 64'd0);
        check_eq("rst_oaddr", lcl_oaddr, 64'd0);
        check_eq("rst_onum", 64'(lcl_onum), 64'd0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  st;
        logic [63:0] ra;
        int          s0;
        int          guard;
        int          k;

        rst = 1'b1; cmd_valid = 1'b0; cmd_addr = 64'd0; cmd_beats = 32'd0;
        cmd_abort = 1'b0; lcl_obusy = 1'b0; lcl_odone = 1'b0; rd_error = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;

        // Alignment and page split, low bits of the address ignored.
        auto_mode = 1'b1;
        s0 = n_starts;
        start_cmd(64'h1000 | 64'h2a, 32'd100);
        wait_done(2000, st);
        check_eq("split_status", 64'(st), 64'd0);
        check_eq("split_starts", 64'(n_starts - s0), 64'd4);
        check_eq("split_left", 64'(exp_q.size()), 64'd0);

        // 4 KB crossing with exact start latency and drain-to-done timing.
        auto_mode = 1'b0;
        lcl_obusy = 1'b0;
        tick();
        start_cmd(64'h0fc0, 32'd3);
        check_eq("no_start_at_accept", 64'(lcl_ostart), 64'd0);
        tick();
        check_eq("first_start_lat", 64'(lcl_ostart), 64'd1);
        tick();
        check_eq("gap_no_start", 64'(lcl_ostart), 64'd0);
        tick();
        check_eq("second_start", 64'(lcl_ostart), 64'd1);
        lcl_odone = 1'b1; tick();
        lcl_odone = 1'b1; tick();
        check_eq("drain_wait", 64'(cmd_done), 64'd0);
        tick();
        check_eq("drain_to_done", 64'(cmd_done), 64'd1);
        check_eq("cross_status", 64'(cmd_status), 64'd0);
        tick();
        check_eq("idle_ready", 64'(cmd_ready), 64'd1);
        check_eq("idle_busy", 64'(busy), 64'd0);

        // Outstanding cap, then abort while stalled.
        s0 = n_starts;
        start_cmd(64'h0, 32'd320);
        repeat (20) tick();
        check_eq("cap_starts", 64'(n_starts - s0), 64'd4);
        check_eq("cap_outstanding", 64'(outstanding), 64'd4);
        lcl_odone = 1'b1;
        tick();
        repeat (10) tick();
        check_eq("cap_one_more", 64'(n_starts - s0), 64'd5);
        cmd_abort = 1'b1;
        repeat (3) tick();
        k = model_out;
        repeat (k) begin
            lcl_odone = 1'b1;
            tick();
        end
        wait_done(10, st);
        check_eq("cap_abort_status", 64'(st), 64'd2);
        cmd_abort = 1'b0;
        exp_q.delete();

        // Abort after the second start of a six-burst command.
        s0 = n_starts;
        start_cmd(64'h0, 32'd192);
        guard = 0;
        while ((n_starts - s0) < 2 && guard < 20) begin
            tick();
            guard++;
        end
        cmd_abort = 1'b1;
        repeat (8) tick();
        check_eq("abort_starts", 64'(n_starts - s0), 64'd2);
        lcl_odone = 1'b1; tick();
        check_eq("abort_done_early1", 64'(cmd_done), 64'd0);
        lcl_odone = 1'b1; tick();
        check_eq("abort_done_early2", 64'(cmd_done), 64'd0);
        tick();
        check_eq("abort_done", 64'(cmd_done), 64'd1);
        check_eq("abort_status", 64'(cmd_status), 64'd2);
        cmd_abort = 1'b0;
        exp_q.delete();

        // Zero-length command.
        s0 = n_starts;
        start_cmd(64'h40, 32'd0);
        check_eq("zero_drain", 64'(cmd_done), 64'd0);
        tick();
        check_eq("zero_done", 64'(cmd_done), 64'd1);
        check_eq("zero_status", 64'(cmd_status), 64'd0);
        check_eq("zero_starts", 64'(n_starts - s0), 64'd0);
        tick();

        // Stray completion while nothing is in flight.
        start_cmd(64'h2000, 32'd1);
        lcl_odone = 1'b1;
        tick();
        lcl_odone = 1'b1;
        tick();
        wait_done(20, st);
        check_eq("stray_status", 64'(st), 64'd1);

        // Master error during a command.
        auto_mode = 1'b1;
        start_cmd(64'h3000, 32'd10);
        rd_error = 4'b0010;
        tick();
        rd_error = 4'd0;
        wait_done(500, st);
        check_eq("rderr_status", 64'(st), 64'd1);

        // Reset with three bursts in flight.
        auto_mode = 1'b0;
        pend.delete();
        lcl_obusy = 1'b0;
        tick();
        s0 = n_starts;
        start_cmd(64'h0, 32'd320);
        guard = 0;
        while ((n_starts - s0) < 3 && guard < 20) begin
            tick();
            guard++;
        end
        check_eq("pre_rst_outstanding", 64'(outstanding), 64'd3);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        model_out = 0;
        tick();
        check_eq("post_rst_ready", 64'(cmd_ready), 64'd1);

        // Random commands against the burst list with a randomly paced master.
        auto_mode = 1'b1;
        for (int n = 0; n < 25; n++) begin
            ra = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) ra[11:6] = 6'($urandom_range(56, 63));
            if ($urandom_range(0, 7) == 0) start_cmd(ra, 32'd0);
            else start_cmd(ra, 32'($urandom_range(1, 300)));
            wait_done(5000, st);
            check_eq("rand_status", 64'(st), 64'd0);
            check_eq("rand_left", 64'(exp_q.size()), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
